// File: rtl/vending_credit_engine.sv
// Vending credit/change engine: coin accumulation, lowest-index vend arbitration, wait timer and greedy change return.
// Optional macro VEND_AUTO_RETURN_EN: wait-timer expiry in CREDIT starts change return like i_trigger_return.
module vending_credit_engine #(
  parameter int unsigned NUM_COINS   = 3,
  parameter int unsigned NUM_ITEMS   = 4,
  parameter int unsigned TOTAL_BITS  = 31,
  parameter int unsigned WAIT_CYCLES = 100
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_COINS*32-1:0] i_coin_value,
  input  logic [NUM_ITEMS*32-1:0] i_item_price,
  input  logic [NUM_COINS-1:0]    i_input_coin,
  input  logic [NUM_ITEMS-1:0]    i_select_item,
  input  logic                    i_trigger_return,
  output logic [NUM_ITEMS-1:0]    o_available_item,
  output logic [NUM_ITEMS-1:0]    o_output_item,
  output logic [NUM_COINS-1:0]    o_return_coin,
  output logic                    o_return_done,
  output logic                    o_coin_reject,
  output logic [TOTAL_BITS-1:0]   o_credit,
  output logic                    o_busy
);
  localparam int unsigned SUM_BITS = TOTAL_BITS + 1;
  localparam int unsigned EXT_BITS = TOTAL_BITS + 2;
  localparam int unsigned CMP_BITS = (TOTAL_BITS > 32) ? TOTAL_BITS : 32;
  localparam int unsigned CNT_BITS = $clog2(WAIT_CYCLES + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_CREDIT, ST_RETURN} state_t;

  state_t                state;
  logic [TOTAL_BITS-1:0] credit;
  logic [CNT_BITS-1:0]   wait_cnt;
  logic                  ret_exit_q;

  logic [SUM_BITS-1:0]   coin_sum;
  logic [NUM_ITEMS-1:0]  affordable;
  logic [NUM_ITEMS-1:0]  vend_onehot;
  logic                  sel_seen;
  logic [TOTAL_BITS-1:0] vend_price;
  logic [TOTAL_BITS-1:0] after_vend;
  logic [EXT_BITS-1:0]   credit_sum;
  logic [TOTAL_BITS-1:0] next_credit;
  logic                  overflow;
  logic                  coin_credited;
  logic                  timer_load;
  logic                  auto_return;
  logic [NUM_COINS-1:0]  ret_onehot;
  logic                  ret_found;
  logic [CMP_BITS-1:0]   ret_value;
  logic [CMP_BITS-1:0]   coin_val;
  logic [TOTAL_BITS-1:0] ret_next;

  always_comb begin
    coin_sum = '0;
    for (int unsigned k = 0; k < NUM_COINS; k++)
      if (i_input_coin[k]) coin_sum = coin_sum + SUM_BITS'(i_coin_value[32*k +: 32]);

    affordable = '0;
    for (int unsigned k = 0; k < NUM_ITEMS; k++)
      affordable[k] = CMP_BITS'(i_item_price[32*k +: 32]) <= CMP_BITS'(credit);

    // Only the lowest requested item is arbitrated; it vends against pre-update credit.
    sel_seen    = 1'b0;
    vend_onehot = '0;
    vend_price  = '0;
    for (int unsigned k = 0; k < NUM_ITEMS; k++) begin
      if (i_select_item[k] && !sel_seen) begin
        sel_seen = 1'b1;
        if (affordable[k]) begin
          vend_onehot[k] = 1'b1;
          vend_price     = TOTAL_BITS'(i_item_price[32*k +: 32]);
        end
      end
    end

    after_vend    = credit - vend_price;
    credit_sum    = EXT_BITS'(after_vend) + EXT_BITS'(coin_sum);
    overflow      = |credit_sum[EXT_BITS-1:TOTAL_BITS];
    coin_credited = (|i_input_coin) && !overflow;
    next_credit   = overflow ? after_vend : credit_sum[TOTAL_BITS-1:0];
    timer_load    = coin_credited || (|vend_onehot);

    // Greedy change: largest nonzero coin not above credit, lowest index on ties.
    ret_found  = 1'b0;
    ret_value  = '0;
    ret_onehot = '0;
    coin_val   = '0;
    for (int unsigned k = 0; k < NUM_COINS; k++) begin
      coin_val = CMP_BITS'(i_coin_value[32*k +: 32]);
      if (coin_val != '0 && coin_val <= CMP_BITS'(credit) && (!ret_found || coin_val > ret_value)) begin
        ret_found     = 1'b1;
        ret_value     = coin_val;
        ret_onehot    = '0;
        ret_onehot[k] = 1'b1;
      end
    end
    ret_next = credit - TOTAL_BITS'(ret_value);
  end

`ifdef VEND_AUTO_RETURN_EN
  assign auto_return = (state == ST_CREDIT) && !timer_load && (wait_cnt <= CNT_BITS'(1));
`else
  assign auto_return = 1'b0;
`endif

  assign o_available_item = affordable & {NUM_ITEMS{state != ST_RETURN}};
  assign o_credit         = credit;
  assign o_busy           = (state == ST_RETURN);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      credit        <= '0;
      wait_cnt      <= '0;
      ret_exit_q    <= 1'b0;
      o_output_item <= '0;
      o_return_coin <= '0;
      o_return_done <= 1'b0;
      o_coin_reject <= 1'b0;
    end else begin
      o_output_item <= '0;
      o_return_coin <= '0;
      o_return_done <= ret_exit_q;
      ret_exit_q    <= 1'b0;
      if (state == ST_RETURN) begin
        o_coin_reject <= |i_input_coin;
        if (ret_found) begin
          o_return_coin <= ret_onehot;
          credit        <= ret_next;
          if (ret_next == '0) begin
            state      <= ST_IDLE;
            ret_exit_q <= 1'b1;
          end
        end else begin
          credit     <= '0;
          state      <= ST_IDLE;
          ret_exit_q <= 1'b1;
        end
      end else begin
        credit        <= next_credit;
        o_output_item <= vend_onehot;
        o_coin_reject <= overflow;
        if (timer_load)
          wait_cnt <= CNT_BITS'(WAIT_CYCLES);
        else if (state == ST_CREDIT && wait_cnt != '0)
          wait_cnt <= wait_cnt - 1'b1;
        if (state == ST_IDLE) begin
          state <= (next_credit != '0) ? ST_CREDIT : ST_IDLE;
        end else if (i_trigger_return || auto_return) begin
          // A same-cycle vend that empties the credit skips RETURN but still reports completion.
          if (next_credit == '0) begin
            state      <= ST_IDLE;
            ret_exit_q <= 1'b1;
          end else begin
            state <= ST_RETURN;
          end
        end else if (next_credit == '0) begin
          state <= ST_IDLE;
        end
      end
    end
  end
endmodule

// File: doc/vending_credit_engine.md
Name: vending_credit_engine

Overview:
- Parametrised, clocked credit and change engine for the vending machine datapath.
- Holds the customer credit register and accumulates inserted coins.
- Arbitrates item selection and vends one item per cycle.
- Runs a wait-time counter, and dispenses change one coin per cycle through a greedy return state machine.

Parameters:
- NUM_COINS, 3, number of coin denominations (bit width of the coin vectors).
- NUM_ITEMS, 4, number of items (bit width of the item vectors).
- TOTAL_BITS, 31, width of the credit register and all totals.
- WAIT_CYCLES, 100, idle cycles before timeout; must be at least 1.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- i_coin_value  input  NUM_COINS*32  packed coin values; coin k at bits [32k+31:32k].
- i_item_price  input  NUM_ITEMS*32  packed item prices; item k at bits [32k+31:32k].
- i_input_coin  input  NUM_COINS  coins inserted this cycle; multiple bits may be set.
- i_select_item  input  NUM_ITEMS  item request this cycle.
- i_trigger_return  input  1  customer change request.
- o_available_item  output  NUM_ITEMS  combinational; bit k = (price[k] <= credit) && state != RETURN.
- o_output_item  output  NUM_ITEMS  registered one-hot vend pulse.
- o_return_coin  output  NUM_COINS  registered one-hot coin-return pulse.
- o_return_done  output  1  registered one-cycle pulse when the return sequence ends.
- o_coin_reject  output  1  registered pulse when inserted coins are not credited.
- o_credit  output  TOTAL_BITS  current credit register.
- o_busy  output  1  high while state == RETURN.

Behaviour:
- Reset: asynchronous, active-high; state=IDLE, credit=0, wait counter=0, all registered outputs 0.
- States are IDLE (credit==0), CREDIT (credit>0) and RETURN.
- Coin sum: the sum of i_coin_value over every set bit of i_input_coin, computed in TOTAL_BITS+1 bits.
- Select arbitration: only the lowest-index set bit of i_select_item is considered.
- A vend occurs only if that item's price <= current credit register (pre-update value); a coin inserted the same cycle cannot fund it.
- On a vend, o_output_item has that bit set the following cycle for exactly 1 cycle.
- A select that is not vendable is silently dropped; no output.
- Next credit = credit + coin sum - vended price.
- If the result exceeds 2^TOTAL_BITS-1, coins are not credited (the vend still applies) and o_coin_reject pulses for 1 cycle.
- Wait counter loads WAIT_CYCLES on any credited coin or vend.
- The wait counter otherwise decrements by 1 per cycle while in CREDIT, saturating at 0.
- Timeout event: counter reaches 0 while in CREDIT.
- IDLE -> CREDIT when the next credit is > 0.
- CREDIT -> IDLE when a vend brings credit to 0.
- CREDIT -> RETURN on i_trigger_return, or on timeout (timeout only under the optional feature).
- If i_trigger_return and a select arrive in the same cycle, the vend happens first, then RETURN is entered with the residual credit.
- If that residual is 0, the engine goes to IDLE instead and pulses o_return_done.
- i_trigger_return in IDLE is ignored.
- RETURN, each cycle: pick coin j with the largest value <= credit (ties go to the lowest index); pulse o_return_coin[j] for 1 cycle; credit -= value[j].
- RETURN exits to IDLE on the cycle credit becomes 0, or when no coin value <= credit; remaining credit is cleared to 0 in that case.
- o_return_done pulses on the exit cycle + 1.
- While in RETURN, i_select_item and i_trigger_return are ignored.
- While in RETURN, any nonzero i_input_coin is not credited and pulses o_coin_reject.
- Coins with value 0 are never selected for return.
- Reset asserted mid-return aborts immediately: no further o_return_coin pulses, credit=0.

Optional Feature:
- Macro: VEND_AUTO_RETURN_EN.
- Defined: timeout in CREDIT forces RETURN exactly as i_trigger_return does.
- Not defined: the wait counter still runs and saturates at 0, but change is returned only on i_trigger_return; credit is held indefinitely.

Test Plan:
- Setup for all scenarios: coins {100,500,1000}, prices {400,500,1000,2000}, WAIT_CYCLES=10.
- Insert 500 then 1000 on separate cycles -> o_credit=1500, o_available_item=0111; select item 2 -> o_output_item=0100 one cycle later, o_credit=500.
- Insert 1000 and select item 2 in the same cycle with credit 0 -> no vend, o_credit=1000. Next cycle select 1011 -> item 0 vends, o_credit=600.
- Credit 1600, i_trigger_return -> o_return_coin pulses 100 (coin 2), 010 (coin 1), 001 (coin 0) on consecutive cycles; o_return_done one cycle later; o_credit=0; o_busy high for 3 cycles.
- With VEND_AUTO_RETURN_EN, credit 500 and no activity -> RETURN entered 10 cycles after the last coin, o_return_coin=010. Without the macro -> credit stays 500 after 50 cycles.
- Set TOTAL_BITS=11 (max 2047), credit 2000, insert 100 -> o_coin_reject pulse, o_credit=2000. Insert 100 during RETURN -> o_coin_reject pulse, not credited.
- Assert reset after the first return pulse of a 1600 refund -> no further o_return_coin pulses; all outputs 0 on the next clock.
